bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum number of accepted requests awaiting rvalid (range 1..4).
REQ-004 SHALL have one clock, clk_i, input, 1 bit; all state updates on its rising edge.
REQ-005 SHALL have reset rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have, per master port m0 (Ibex instruction) and m1 (Ibex data), these ports:
  - mX_req, input, 1 bit;
  - mX_we, input, 1 bit;
  - mX_be, input, DATA_WIDTH/8 bits;
  - mX_addr, input, ADDR_WIDTH bits;
  - mX_wdata, input, DATA_WIDTH bits;
  - mX_gnt, output, 1 bit;
  - mX_rvalid, output, 1 bit;
  - mX_rdata, output, DATA_WIDTH bits;
  - mX_err, output, 1 bit.
REQ-007 SHALL have slave-side ports toward the RAM bus slave:
  - s_req, output, 1 bit;
  - s_we, output, 1 bit;
  - s_be, output, DATA_WIDTH/8 bits;
  - s_addr, output, ADDR_WIDTH bits;
  - s_wdata, output, DATA_WIDTH bits;
  - s_gnt, input, 1 bit;
  - s_rvalid, input, 1 bit;
  - s_rdata, input, DATA_WIDTH bits;
  - s_err, input, 1 bit.
REQ-008 SHALL have protocol_err_o, output, 1 bit: sticky flag set when s_rvalid arrives with no outstanding request.

Function
REQ-009 SHALL keep a priority register prio_q (0 = m0 preferred, 1 = m1 preferred).
REQ-010 SHALL compute a stall condition, full = (outstanding count == MAX_OUTSTANDING).
REQ-011 SHALL select the winner combinationally, as follows:
  - only one mX_req high: that master wins;
  - both high: master prio_q wins;
  - none high: no winner.
REQ-012 SHALL drive s_req = winner exists && !full; while full, s_req = 0 and both mX_gnt = 0.
REQ-013 SHALL forward the winner's we/be/addr/wdata to s_*; with no winner, s_we = 0, s_be = 0, s_addr = 0, s_wdata = 0.
REQ-014 SHALL drive mX_gnt = s_req && s_gnt && (winner == X); the loser's gnt is 0 and its request stays pending.
REQ-015 SHALL define a handshake as s_req && s_gnt in a cycle; requests hold until granted.
REQ-016 SHALL, on each handshake, push the winner id into an owner FIFO of depth MAX_OUTSTANDING.
REQ-017 SHALL, on a handshake taken with both masters requesting, set prio_q to the non-winning master.
REQ-018 SHALL otherwise leave prio_q unchanged.
REQ-019 SHALL, on s_rvalid with count > 0, pop the FIFO head H and drive the following in the same cycle (combinational, zero added latency):
  - mH_rvalid = 1, mH_rdata = s_rdata, mH_err = s_err;
  - the non-owner sees rvalid = 0, rdata = 0, err = 0.
REQ-020 SHALL return responses strictly in handshake order (FIFO order).
REQ-021 SHALL, on simultaneous push and pop, leave the count unchanged and keep both the new entry and the popped entry correct.
REQ-022 SHALL evaluate full from the registered count only; a same-cycle pop does not relieve the stall.
REQ-023 SHALL, on s_rvalid with count == 0, drive no mX_rvalid, leave the FIFO unchanged, and set protocol_err_o = 1 from the next cycle until reset.
REQ-024 SHALL wrap FIFO read/write pointers modulo MAX_OUTSTANDING.
REQ-025 SHALL implement the count as a saturating-free counter of width clog2(MAX_OUTSTANDING+1).
REQ-026 SHALL support back-to-back handshakes every cycle against a slave with gnt = req and rvalid one cycle later, sustaining one transfer per cycle with MAX_OUTSTANDING >= 2.

Reset
REQ-027 SHALL, while rst_i is high at a clock edge, clear the count, FIFO pointers, prio_q (to 0) and protocol_err_o.
REQ-028 SHALL discard requests in flight when reset is asserted; s_rvalid in the first cycle after reset deassertion with count == 0 obeys REQ-023.
REQ-029 SHALL keep s_req, all mX_gnt and all mX_rvalid at 0 while rst_i is high.

Verification
REQ-030 SHALL cover single master: m1 read addr 0x100 → m1_gnt in same cycle; next cycle s_rvalid with rdata 0xDEADBEEF → m1_rvalid = 1, m1_rdata = 0xDEADBEEF, m0_rvalid = 0.
REQ-031 SHALL cover contention: m0 and m1 req held high 4 cycles after reset → grants m0, m1, m0, m1; each rvalid is routed to the matching master.
REQ-032 SHALL cover the full stall: MAX_OUTSTANDING = 2 and a slave with rvalid delayed 3 cycles → two handshakes, then s_req = 0 until first rvalid; the third handshake occurs the cycle after count drops to 1.
REQ-033 SHALL cover a spurious response: s_rvalid = 1 with count == 0 → no mX_rvalid, and protocol_err_o = 1 next cycle and stays 1.
REQ-034 SHALL cover reset mid-operation: rst_i asserted with count == 2 → next cycle count = 0, prio_q = 0, and a later m0+m1 request grants m0 first.
REQ-035 SHALL cover a write: m0 write with be = 4'b0011 and wdata 0x12345678 → s_we = 1, s_be = 0011, s_wdata forwarded, m0_gnt = 1; the following rvalid is routed to m0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master to one-slave bus arbiter for Ibex instruction/data ports.
// Tracks response ownership in an in-order FIFO sized by MAX_OUTSTANDING.
module bus_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_err,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_err,
  output logic                    s_req,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_be,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic                    s_gnt,
  input  logic                    s_rvalid,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_err,
  output logic                    protocol_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [CW-1:0]              count_q, count_d;
  logic [PW-1:0]              wptr_q, wptr_d;
  logic [PW-1:0]              rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic                       prio_q, prio_d;
  logic                       perr_q, perr_d;

  logic both, has_win, win, full, hs, pop, spurious, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    both     = m0_req & m1_req;
    has_win  = m0_req | m1_req;
    win      = both ? prio_q : m1_req;
    full     = (count_q == CW'(MAX_OUTSTANDING));
    s_req    = has_win & ~full & ~rst_i;
    hs       = s_req & s_gnt;
    m0_gnt   = hs & ~win;
    m1_gnt   = hs & win;
    pop      = s_rvalid & (count_q != '0) & ~rst_i;
    spurious = s_rvalid & (count_q == '0) & ~rst_i;
    head     = owner_q[rptr_q];
  end

  always_comb begin
    s_we    = 1'b0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (has_win && !win) begin
      s_we    = m0_we;
      s_be    = m0_be;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (has_win && win) begin
      s_we    = m1_we;
      s_be    = m1_be;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  // Response steering: zero-latency, owner taken from FIFO head
  always_comb begin
    m0_rvalid = pop & ~head;
    m1_rvalid = pop & head;
    m0_rdata  = m0_rvalid ? s_rdata : '0;
    m1_rdata  = m1_rvalid ? s_rdata : '0;
    m0_err    = m0_rvalid & s_err;
    m1_err    = m1_rvalid & s_err;
  end

  always_comb begin
    owner_d = owner_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    prio_d  = prio_q;
    perr_d  = perr_q | spurious;
    if (hs) begin
      owner_d[wptr_q] = win;
      wptr_d          = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (hs && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!hs && pop) begin
      count_d = count_q - CW'(1);
    end
    if (hs && both) begin
      prio_d = ~win;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      owner_q <= '0;
      prio_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      perr_q  <= perr_d;
    end
  end

  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_bus_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [BW-1:0] m0_be;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [BW-1:0] m1_be;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          s_req, s_we, s_gnt, s_rvalid, s_err;
  logic [BW-1:0] s_be;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          protocol_err_o;

  bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_gnt(s_gnt), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .s_err(s_err),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: list of owners awaiting responses
  int q[$];
  bit prio_m, perr_m;
  int win_m;
  bit hs_m, pop_m;
  bit e_sreq, e_g0, e_g1, e_rv0, e_rv1, e_err0, e_err1, e_we;
  logic [BW-1:0] e_be;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd0, e_rd1;

  task automatic model_eval();
    win_m = -1;
    if (m0_req && m1_req) win_m = prio_m;
    else if (m0_req) win_m = 0;
    else if (m1_req) win_m = 1;
    e_sreq = !rst_i && win_m >= 0 && q.size() < MAXO;
    hs_m   = e_sreq && s_gnt;
    e_g0   = hs_m && win_m == 0;
    e_g1   = hs_m && win_m == 1;
    e_we = 0; e_be = '0; e_addr = '0; e_wd = '0;
    if (win_m == 0) begin
      e_we = m0_we; e_be = m0_be; e_addr = m0_addr; e_wd = m0_wdata;
    end else if (win_m == 1) begin
      e_we = m1_we; e_be = m1_be; e_addr = m1_addr; e_wd = m1_wdata;
    end
    pop_m  = !rst_i && s_rvalid && q.size() > 0;
    e_rv0  = pop_m && q[0] == 0;
    e_rv1  = pop_m && q[0] == 1;
    e_rd0  = e_rv0 ? s_rdata : '0;
    e_rd1  = e_rv1 ? s_rdata : '0;
    e_err0 = e_rv0 && s_err;
    e_err1 = e_rv1 && s_err;
  endtask

  task automatic model_step();
    model_eval();
    if (rst_i) begin
      q.delete();
      prio_m = 0;
      perr_m = 0;
    end else begin
      if (s_rvalid && q.size() == 0) perr_m = 1;
      if (pop_m) void'(q.pop_front());
      if (hs_m) begin
        q.push_back(win_m);
        if (m0_req && m1_req) prio_m = (win_m == 0);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    s_gnt = 0; s_rvalid = 0; s_rdata = '0; s_err = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    advance();
    rst_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1;
    #1;
    checks++;
    if ({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=00000",
               {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    advance();
    advance();
    idle();
    rst_i = 0;
    #1;
    checks++;
    if (protocol_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_perr got=%b exp=0", protocol_err_o);
    end
    advance();
  endtask

  task automatic test_single();
    idle();
    m1_req = 1; m1_addr = 32'h100; s_gnt = 1;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, s_we} !== 3'b010 || s_addr !== 32'h100) begin
      failures++;
      $display("FAIL single_gnt got=%b/%h exp=010/00000100",
               {m0_gnt, m1_gnt, s_we}, s_addr);
    end
    advance();
    idle();
    s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'hDEADBEEF
        || m0_rdata !== 32'h0) begin
      failures++;
      $display("FAIL single_rvalid got=%b/%h exp=01/deadbeef",
               {m0_rvalid, m1_rvalid}, m1_rdata);
    end
    advance();
  endtask

  task automatic test_contention();
    bit [1:0] exp_g [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      m0_req = (k < 4); m1_req = (k < 4); s_gnt = 1;
      s_rvalid = (k > 0); s_rdata = 32'hC000_0000 + k;
      #1;
      if (k < 4) begin
        checks++;
        if ({m0_gnt, m1_gnt} !== exp_g[k]) begin
          failures++;
          $display("FAIL contention_gnt%0d got=%b exp=%b",
                   k, {m0_gnt, m1_gnt}, exp_g[k]);
        end
      end
      if (k > 0) begin
        checks++;
        if ({m0_rvalid, m1_rvalid} !== exp_g[k-1]) begin
          failures++;
          $display("FAIL contention_rv%0d got=%b exp=%b",
                   k, {m0_rvalid, m1_rvalid}, exp_g[k-1]);
        end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_full();
    bit exp_req [5] = '{1, 1, 0, 0, 1};
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      m0_req = (c < 5); m0_addr = 32'h200 + c; s_gnt = 1;
      s_rvalid = (c >= 3); s_rdata = 32'hF000_0000 + c;
      #1;
      if (c < 5) begin
        checks++;
        if ({s_req, m0_gnt} !== {exp_req[c], exp_req[c]}) begin
          failures++;
          $display("FAIL full_sreq%0d got=%b exp=%b",
                   c, {s_req, m0_gnt}, {exp_req[c], exp_req[c]});
        end
      end
      if (c >= 3) begin
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hF000_0000 + c) begin
          failures++;
          $display("FAIL full_rv%0d got=%b/%h exp=1/%h",
                   c, m0_rvalid, m0_rdata, 32'hF000_0000 + c);
        end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_write();
    idle();
    m0_req = 1; m0_we = 1; m0_be = 4'b0011;
    m0_addr = 32'h40; m0_wdata = 32'h12345678; s_gnt = 1;
    #1;
    checks++;
    if ({s_we, s_be, m0_gnt} !== 6'b1_0011_1 || s_wdata !== 32'h12345678) begin
      failures++;
      $display("FAIL write_fwd got=%b/%h exp=100111/12345678",
               {s_we, s_be, m0_gnt}, s_wdata);
    end
    advance();
    idle();
    s_rvalid = 1;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10) begin
      failures++;
      $display("FAIL write_rv got=%b exp=10", {m0_rvalid, m1_rvalid});
    end
    advance();
    idle();
  endtask

  task automatic test_reset_mid();
    bit [2:0] exp_g [7] = '{3'b110, 3'b110, 3'b000, 3'b110,
                            3'b101, 3'b000, 3'b000};
    bit [1:0] exp_rv [7] = '{2'b00, 2'b00, 2'b00, 2'b00,
                             2'b00, 2'b10, 2'b01};
    for (int c = 0; c < 7; c++) begin
      idle();
      rst_i = (c == 2);
      m0_req = (c < 6); m1_req = (c >= 1 && c < 6); s_gnt = 1;
      s_rvalid = (c >= 5);
      #1;
      checks++;
      if ({s_req, m0_gnt, m1_gnt} !== exp_g[c]
          || {m0_rvalid, m1_rvalid} !== exp_rv[c]) begin
        failures++;
        $display("FAIL reset_mid%0d got=%b/%b exp=%b/%b", c,
                 {s_req, m0_gnt, m1_gnt}, {m0_rvalid, m1_rvalid},
                 exp_g[c], exp_rv[c]);
      end
      advance();
    end
    rst_i = 0;
    idle();
  endtask

  task automatic test_random();
    bit g0, g1;
    idle();
    g0 = 0; g1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!m0_req || g0) begin
        m0_req = ($urandom % 3) != 0; m0_we = $urandom;
        m0_be = $urandom; m0_addr = $urandom; m0_wdata = $urandom;
      end
      if (!m1_req || g1) begin
        m1_req = ($urandom % 3) != 0; m1_we = $urandom;
        m1_be = $urandom; m1_addr = $urandom; m1_wdata = $urandom;
      end
      s_gnt    = ($urandom % 4) != 0;
      s_rvalid = q.size() > 0 && ($urandom % 2);
      s_rdata  = $urandom;
      s_err    = ($urandom % 5) == 0;
      #1;
      model_eval();
      g0 = e_g0; g1 = e_g1;
      checks++;
      if ({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
           protocol_err_o} !==
          {e_sreq, e_g0, e_g1, e_rv0, e_rv1, e_err0, e_err1, perr_m}) begin
        failures++;
        $display("FAIL rand_ctl%0d got=%b exp=%b", i,
                 {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err,
                  m1_err, protocol_err_o},
                 {e_sreq, e_g0, e_g1, e_rv0, e_rv1, e_err0, e_err1, perr_m});
      end
      checks++;
      if ({s_we, s_be, s_addr, s_wdata, m0_rdata, m1_rdata} !==
          {e_we, e_be, e_addr, e_wd, e_rd0, e_rd1}) begin
        failures++;
        $display("FAIL rand_data%0d got=%h exp=%h", i,
                 {s_we, s_be, s_addr, s_wdata, m0_rdata, m1_rdata},
                 {e_we, e_be, e_addr, e_wd, e_rd0, e_rd1});
      end
      advance();
    end
    idle();
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      s_rvalid = 1;
      advance();
    end
    idle();
  endtask

  task automatic test_spurious();
    idle();
    s_rvalid = 1; s_rdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, protocol_err_o} !== 3'b000) begin
      failures++;
      $display("FAIL spurious_rv got=%b exp=000",
               {m0_rvalid, m1_rvalid, protocol_err_o});
    end
    advance();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (protocol_err_o !== 1'b1) begin
        failures++;
        $display("FAIL spurious_sticky%0d got=%b exp=1", c, protocol_err_o);
      end
      advance();
    end
  endtask

  initial begin
    idle();
    rst_i = 1;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_write();
    test_reset_mid();
    test_random();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
